// File: rtl/logic_sweep_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : logic_sweep_checker_if
// Description : Control, result and stimulus/response bundle of the sweep checker.
// Revision    : 1.0 - initial release
// ============================================================================
interface logic_sweep_checker_if;
    logic       start;
    logic       a_o;
    logic       b_o;
    logic       c_o;
    logic       x_i;
    logic       y_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [7:0] fail_mask;
    logic [2:0] first_fail_vec;
    logic       fail_valid;

    // master: the environment that requests sweeps and hosts the block under test
    modport master (
        output start, x_i, y_i,
        input  a_o, b_o, c_o, busy, done, pass, err_count, fail_mask,
               first_fail_vec, fail_valid
    );

    modport slave (
        input  start, x_i, y_i,
        output a_o, b_o, c_o, busy, done, pass, err_count, fail_mask,
               first_fail_vec, fail_valid
    );
endinterface
`default_nettype wire

// File: rtl/logic_sweep_checker.sv
`default_nettype none
// ============================================================================
// Module      : logic_sweep_checker
// Description : Exhaustive 8-vector sweep of a 3-in/2-out logic block, logging mismatches.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_sweep_checker #(
    parameter int SETTLE_CYCLES = 2
) (
    input  wire logic              clk,
    input  wire logic              rst,
    logic_sweep_checker_if.slave   bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_drive  = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_sample = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    // Loaded one below the target so the final SETTLE cycle is the one that sees zero.
    localparam logic [3:0] c_settle_load = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    logic [2:0] r_state;
    logic [2:0] r_vec;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_c;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_err_count;
    logic [7:0] r_fail_mask;
    logic [2:0] r_first_fail_vec;
    logic       r_fail_valid;

    logic w_x_exp;
    logic w_y_exp;
    logic w_mismatch;

    assign w_x_exp    = ~(r_c ^ (r_a | r_b));
    assign w_y_exp    = r_a & r_b;
    assign w_mismatch = (bus.x_i != w_x_exp) || (bus.y_i != w_y_exp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= c_st_idle;
            r_vec            <= 3'd0;
            r_cnt            <= 4'd0;
            r_a              <= 1'b0;
            r_b              <= 1'b0;
            r_c              <= 1'b0;
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_err_count      <= 4'd0;
            r_fail_mask      <= 8'd0;
            r_first_fail_vec <= 3'd0;
            r_fail_valid     <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (bus.start) begin
                        r_err_count      <= 4'd0;
                        r_fail_mask      <= 8'd0;
                        r_first_fail_vec <= 3'd0;
                        r_fail_valid     <= 1'b0;
                        r_vec            <= 3'd0;
                        r_done           <= 1'b0;
                        r_pass           <= 1'b0;
                        r_busy           <= 1'b1;
                        r_state          <= c_st_drive;
                    end
                end
                c_st_drive: begin
                    r_a <= r_vec[2];
                    r_b <= r_vec[1];
                    r_c <= r_vec[0];
                    if (SETTLE_CYCLES == 0) begin
                        r_state <= c_st_sample;
                    end else begin
                        r_cnt   <= c_settle_load;
                        r_state <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= c_st_sample;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                c_st_sample: begin
                    if (w_mismatch) begin
                        r_err_count        <= r_err_count + 4'd1;
                        r_fail_mask[r_vec] <= 1'b1;
                        if (!r_fail_valid) begin
                            r_first_fail_vec <= r_vec;
                            r_fail_valid     <= 1'b1;
                        end
                    end
                    if (r_vec == 3'd7) begin
                        // pass must reflect this last sample, which is not yet in r_err_count
                        r_pass  <= !w_mismatch && (r_err_count == 4'd0);
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                        r_c     <= 1'b0;
                        r_state <= c_st_done;
                    end else begin
                        r_vec   <= r_vec + 3'd1;
                        r_state <= c_st_drive;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.a_o            = r_a;
    assign bus.b_o            = r_b;
    assign bus.c_o            = r_c;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err_count;
    assign bus.fail_mask      = r_fail_mask;
    assign bus.first_fail_vec = r_first_fail_vec;
    assign bus.fail_valid     = r_fail_valid;

endmodule
`default_nettype wire
